dm_port_arbiter: RTL and testbench

- Shares one single-port synchronous data memory (dm) between two requesters: the CPU load/store path and the checker/scoreboard read path.
- The CPU has priority by default. A starvation counter forces a checker grant after MAX_WAIT consecutive lost arbitrations.
- Read data returns one cycle after grant and is steered to the requester that won that grant.
- The block sits between the CPU memory stage, the checker, and the dm instance.

---
 rtl/dm_port_arbiter_if.sv | 38 +++
 rtl/dm_port_arbiter.sv | 98 +++++++++
 tb/tb_dm_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU, checker and data-memory signals around dm_port_arbiter.
// The arbiter uses the slave view; the CPU, checker and dm side uses the master view.
interface dm_port_arbiter_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          chk_req;
  logic [AW-1:0] chk_addr;
  logic          chk_gnt;
  logic          chk_rvalid;
  logic [DW-1:0] chk_rdata;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, chk_req, chk_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, chk_gnt, chk_rvalid, chk_rdata,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, chk_req, chk_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, chk_gnt, chk_rvalid, chk_rdata,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Arbitrates the CPU and checker onto one single-port dm; the CPU has priority with anti-starvation.
// Define DM_ARB_STATS_EN to add saturating grant/conflict statistics counters.
module dm_port_arbiter #(
  parameter int unsigned AW       = 7,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef DM_ARB_STATS_EN
  output logic [15:0] cpu_gnt_cnt,
  output logic [15:0] chk_gnt_cnt,
  output logic [15:0] conflict_cnt,
`endif
  dm_port_arbiter_if.slave bus
);

  localparam logic [1:0] TagNone  = 2'd0;
  localparam logic [1:0] TagCpuRd = 2'd1;
  localparam logic [1:0] TagChkRd = 2'd2;
  localparam logic [3:0] WaitMax  = 4'(MAX_WAIT);

  logic [3:0] wait_q, wait_d;
  logic [1:0] rtag_q, rtag_d;
  logic       both_req, same_addr_wr, force_chk;
  logic       cpu_gnt, chk_gnt, cpu_rvalid, chk_rvalid;

  always_comb begin
    both_req     = bus.cpu_req & bus.chk_req;
    // A CPU store to the checker's address goes first so the checker sees post-store data.
    same_addr_wr = bus.cpu_we & (bus.cpu_addr == bus.chk_addr);
    force_chk    = both_req & (wait_q == WaitMax) & ~same_addr_wr;
    cpu_gnt      = ~reset & bus.cpu_req & ~force_chk;
    chk_gnt      = ~reset & bus.chk_req & (~bus.cpu_req | force_chk);
  end

  always_comb begin
    wait_d = wait_q;
    if (!bus.chk_req || chk_gnt) begin
      wait_d = 4'd0;
    end else if (wait_q < WaitMax) begin
      wait_d = wait_q + 4'd1;
    end
    rtag_d = TagNone;
    if (chk_gnt) begin
      rtag_d = TagChkRd;
    end else if (cpu_gnt && !bus.cpu_we) begin
      rtag_d = TagCpuRd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= 4'd0;
      rtag_q <= TagNone;
    end else begin
      wait_q <= wait_d;
      rtag_q <= rtag_d;
    end
  end

  // rtag_q may still hold a tag in the first reset cycle; drop that return.
  assign cpu_rvalid     = ~reset & (rtag_q == TagCpuRd);
  assign chk_rvalid     = ~reset & (rtag_q == TagChkRd);

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.chk_gnt    = chk_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.chk_rvalid = chk_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.chk_rdata  = chk_rvalid ? bus.mem_rdata : '0;

  assign bus.mem_wr     = cpu_gnt & bus.cpu_we;
  assign bus.mem_rd     = (cpu_gnt & ~bus.cpu_we) | chk_gnt;
  assign bus.mem_addr   = chk_gnt ? bus.chk_addr : (cpu_gnt ? bus.cpu_addr : '0);
  assign bus.mem_wdata  = (cpu_gnt & bus.cpu_we) ? bus.cpu_wdata : '0;

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_gnt_cnt  <= 16'd0;
      chk_gnt_cnt  <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (cpu_gnt && cpu_gnt_cnt != 16'hffff) begin
        cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
      end
      if (chk_gnt && chk_gnt_cnt != 16'hffff) begin
        chk_gnt_cnt <= chk_gnt_cnt + 16'd1;
      end
      if (both_req && conflict_cnt != 16'hffff) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized and directed bench for dm_port_arbiter against a behavioural arbitration/memory model.
module tb_dm_port_arbiter;
  localparam int unsigned AW       = 7;
  localparam int unsigned DW       = 32;
  localparam int          MAX_WAIT = 4;
  localparam int          Depth    = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DM_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, chk_gnt_cnt, conflict_cnt;
  int s_cpu = 0, s_chk = 0, s_conf = 0;
`endif

  dm_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef DM_ARB_STATS_EN
    .cpu_gnt_cnt (cpu_gnt_cnt),
    .chk_gnt_cnt (chk_gnt_cnt),
    .conflict_cnt(conflict_cnt),
`endif
    .bus         (bus)
  );

  // Data memory: synchronous single port, read data one cycle after mem_rd.
  logic [DW-1:0] dm [Depth];
  always @(posedge clk) begin
    if (bus.mem_wr) dm[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= dm[bus.mem_addr];
  end

  int            checks = 0, errors = 0;
  int            m_wait = 0;       // consecutive checker losses
  bit            pend_cpu = 0, pend_chk = 0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] ref_mem [Depth];
  bit            e_cg, e_kg;

  task automatic tick(input bit rst, input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input bit kreq, input logic [AW-1:0] kaddr);
    logic          x_wr, x_rd;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, x_crd, x_krd;
    @(negedge clk);
    reset         = rst;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.chk_req   = kreq;
    bus.chk_addr  = kaddr;
    #1;
    e_cg = 1'b0;
    e_kg = 1'b0;
    if (!rst) begin
      if (creq && kreq && m_wait >= MAX_WAIT && !(cwe && caddr == kaddr)) e_kg = 1'b1;
      else if (creq) e_cg = 1'b1;
      else if (kreq) e_kg = 1'b1;
    end
    x_wr    = e_cg && cwe;
    x_rd    = (e_cg && !cwe) || e_kg;
    x_addr  = e_kg ? kaddr : (e_cg ? caddr : '0);
    x_wdata = x_wr ? cwd : '0;
    x_crd   = (pend_cpu && !rst) ? pend_data : '0;
    x_krd   = (pend_chk && !rst) ? pend_data : '0;

    checks++;
    if ({bus.cpu_gnt, bus.chk_gnt, bus.mem_wr, bus.mem_rd} !== {e_cg, e_kg, x_wr, x_rd}) begin
      errors++;
      $display("FAIL strobes t=%0t gnt_cpu/gnt_chk/wr/rd got %b expected %b", $time,
               {bus.cpu_gnt, bus.chk_gnt, bus.mem_wr, bus.mem_rd}, {e_cg, e_kg, x_wr, x_rd});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {x_addr, x_wdata}) begin
      errors++;
      $display("FAIL mem_bus t=%0t addr/wdata got %h/%h expected %h/%h", $time,
               bus.mem_addr, bus.mem_wdata, x_addr, x_wdata);
    end
    checks++;
    if ({bus.cpu_rvalid, bus.chk_rvalid} !== {pend_cpu && !rst, pend_chk && !rst}) begin
      errors++;
      $display("FAIL rvalid t=%0t cpu/chk got %b%b expected %b%b", $time, bus.cpu_rvalid,
               bus.chk_rvalid, pend_cpu && !rst, pend_chk && !rst);
    end
    checks++;
    if ({bus.cpu_rdata, bus.chk_rdata} !== {x_crd, x_krd}) begin
      errors++;
      $display("FAIL rdata t=%0t cpu/chk got %h/%h expected %h/%h", $time, bus.cpu_rdata,
               bus.chk_rdata, x_crd, x_krd);
    end
`ifdef DM_ARB_STATS_EN
    checks++;
    if ({cpu_gnt_cnt, chk_gnt_cnt, conflict_cnt} !== {16'(s_cpu), 16'(s_chk), 16'(s_conf)}) begin
      errors++;
      $display("FAIL stats t=%0t got %0d/%0d/%0d expected %0d/%0d/%0d", $time, cpu_gnt_cnt,
               chk_gnt_cnt, conflict_cnt, s_cpu, s_chk, s_conf);
    end
    if (rst) begin
      s_cpu = 0; s_chk = 0; s_conf = 0;
    end else begin
      if (e_cg && s_cpu < 65535) s_cpu++;
      if (e_kg && s_chk < 65535) s_chk++;
      if (creq && kreq && s_conf < 65535) s_conf++;
    end
`endif
    if (rst) begin
      m_wait   = 0;
      pend_cpu = 0;
      pend_chk = 0;
    end else begin
      pend_cpu  = e_cg && !cwe;
      pend_chk  = e_kg;
      pend_data = e_kg ? ref_mem[kaddr] : ref_mem[caddr];
      if (x_wr) ref_mem[caddr] = cwd;
      if (kreq && !e_kg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
      else m_wait = 0;
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 7'h03, 32'h1234, 1'b1, 7'h04);
      checks++;
      if ({bus.cpu_gnt, bus.chk_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== '0)
      begin
        errors++;
        $display("FAIL reset_outputs gnt/rd/wr/addr/wdata not all zero: %b%b%b%b %h %h",
                 bus.cpu_gnt, bus.chk_gnt, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < Depth; i++) tick(1'b0, 1'b1, 1'b1, AW'(i), $urandom, 1'b0, '0);
    idle();
  endtask

  task automatic test_write_then_read();
    tick(1'b0, 1'b1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 7'h05);
    idle();
    checks++;
    if (bus.chk_rvalid !== 1'b1 || bus.chk_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL raw_chk_read got rvalid=%b data=%h expected 1/deadbeef", bus.chk_rvalid,
               bus.chk_rdata);
    end
  endtask

  task automatic test_starvation();
    idle();
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1, 1'b0, AW'($urandom), '0, 1'b1, AW'($urandom));
      checks++;
      if (bus.chk_gnt !== ((i % 5) == 4)) begin
        errors++;
        $display("FAIL starve_pattern cycle %0d chk_gnt got %b expected %b", i, bus.chk_gnt,
                 (i % 5) == 4);
      end
    end
  endtask

  task automatic test_forced_write();
    logic [DW-1:0] val;
    val = $urandom;
    idle();
    for (int i = 0; i < MAX_WAIT; i++) tick(1'b0, 1'b1, 1'b0, 7'h20, '0, 1'b1, 7'h10);
    tick(1'b0, 1'b1, 1'b1, 7'h10, val, 1'b1, 7'h10);
    checks++;
    if ({bus.cpu_gnt, bus.chk_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL forced_write_gnt cpu/chk got %b%b expected 10", bus.cpu_gnt, bus.chk_gnt);
    end
    tick(1'b0, 1'b1, 1'b0, 7'h20, '0, 1'b1, 7'h10);
    checks++;
    if ({bus.cpu_gnt, bus.chk_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL forced_chk_gnt cpu/chk got %b%b expected 01", bus.cpu_gnt, bus.chk_gnt);
    end
    idle();
    checks++;
    if (bus.chk_rdata !== val) begin
      errors++;
      $display("FAIL forced_read_data got %h expected %h", bus.chk_rdata, val);
    end
  endtask

  task automatic test_interleave();
    int cpu_seen = 0, chk_seen = 0;
    idle();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: tick(1'b0, 1'b1, 1'b0, 7'h01, '0, 1'b0, '0);
        1: tick(1'b0, 1'b1, 1'b0, 7'h02, '0, 1'b0, '0);
        2: tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 7'h03);
        default: idle();
      endcase
      if (bus.cpu_rvalid) begin
        checks++;
        if (bus.cpu_rdata !== ref_mem[cpu_seen == 0 ? 1 : 2]) begin
          errors++;
          $display("FAIL interleave_cpu_data pulse %0d got %h", cpu_seen, bus.cpu_rdata);
        end
        cpu_seen++;
      end
      if (bus.chk_rvalid) begin
        checks++;
        if (bus.chk_rdata !== ref_mem[3]) begin
          errors++;
          $display("FAIL interleave_chk_data got %h expected %h", bus.chk_rdata, ref_mem[3]);
        end
        chk_seen++;
      end
    end
    checks++;
    if (cpu_seen != 2 || chk_seen != 1) begin
      errors++;
      $display("FAIL interleave_pulses cpu/chk got %0d/%0d expected 2/1", cpu_seen, chk_seen);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    tick(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 7'h09);
    for (int i = 0; i < 2; i++) begin
      tick(i == 0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      checks++;
      if (bus.chk_rvalid !== 1'b0 || bus.chk_rdata !== '0) begin
        errors++;
        $display("FAIL reset_drop cycle %0d chk_rvalid=%b data=%h expected 0/0", i,
                 bus.chk_rvalid, bus.chk_rdata);
      end
    end
  endtask

  task automatic test_random();
    bit            c_pend = 0, c_we = 0, k_pend = 0;
    logic [AW-1:0] c_addr = '0, k_addr = '0;
    logic [DW-1:0] c_wd = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!c_pend && ($urandom % 3) != 0) begin
        c_pend = 1; c_we = $urandom % 2; c_addr = AW'($urandom % 8); c_wd = $urandom;
      end
      if (!k_pend && ($urandom % 2) != 0) begin
        k_pend = 1; k_addr = AW'($urandom % 8);
      end
      tick(($urandom % 200) == 0, c_pend, c_we, c_addr, c_wd, k_pend, k_addr);
      if (e_cg) c_pend = 0;
      if (e_kg) k_pend = 0;
      checks++;
      if (bus.cpu_gnt && bus.chk_gnt) begin
        errors++;
        $display("FAIL random_exclusive cycle %0d got two grants expected at most one", n);
      end
    end
    idle();
  endtask

`ifdef DM_ARB_STATS_EN
  task automatic test_stats();
    tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1, AW'(i + 64));
    idle();
    checks++;
    if (conflict_cnt !== 16'd10 || cpu_gnt_cnt !== 16'd8 || chk_gnt_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats_dual conflict/cpu/chk got %0d/%0d/%0d expected 10/8/2",
               conflict_cnt, cpu_gnt_cnt, chk_gnt_cnt);
    end
  endtask
`endif

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.chk_req   = 1'b0;
    bus.chk_addr  = '0;
    test_reset();
    test_fill();
    test_write_then_read();
    test_starvation();
    test_forced_write();
    test_interleave();
    test_reset_mid();
    test_random();
`ifdef DM_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
